wb_arbiter: RTL and testbench

//  Writeback stage fed by the execute result buffer. Merges two ALU results and one LSQ/memory

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_pend_fifo.sv | 77 +++++++
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: entry layout {pc,rob,rd,res} and port count.
package wb_arbiter_pkg;

    localparam int unsigned NUM_WB_PORTS = 2;
    localparam int unsigned WB_RES_W     = 32;
    localparam int unsigned WB_RD_W      = 6;
    localparam int unsigned WB_ROB_W     = 6;
    localparam int unsigned WB_PC_W      = 12;
    localparam int unsigned WB_ENTRY_W   = WB_PC_W + WB_ROB_W + WB_RD_W + WB_RES_W;

    typedef struct packed {
        logic [WB_PC_W-1:0]  pc;
        logic [WB_ROB_W-1:0] rob;
        logic [WB_RD_W-1:0]  rd;
        logic [WB_RES_W-1:0] res;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_pend_fifo.sv
// Pending-result FIFO: up to 3 compacted pushes and 2 pops per cycle.
// Pushes beyond free space (after same-cycle pops) are dropped and flagged.
module wb_pend_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned PEND_DEPTH = 8,
    localparam int unsigned PW = $clog2(PEND_DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    i_push_valid,
    input  wb_entry_t     i_push_data [3],
    input  logic [1:0]    i_pop_cnt,
    output logic [CW-1:0] o_count,
    output logic [1:0]    o_push_cnt,
    output logic          o_ovf,
    output wb_entry_t     o_head,
    output wb_entry_t     o_head1
);

    wb_entry_t     r_mem [PEND_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_space;
    logic [1:0]    w_acc;
    logic [1:0]    w_req;
    logic [2:0]    w_wr_en;
    wb_entry_t     w_wr_data [3];

    always_comb begin
        w_space   = CW'(PEND_DEPTH) - r_count + CW'(i_pop_cnt);
        w_acc     = 2'd0;
        w_req     = 2'd0;
        w_wr_en   = 3'b000;
        w_wr_data = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (i_push_valid[i]) begin
                w_req = w_req + 2'd1;
                if (CW'(w_acc) < w_space) begin
                    w_wr_en[w_acc]   = 1'b1;
                    w_wr_data[w_acc] = i_push_data[i];
                    w_acc            = w_acc + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 3; j++) begin
                if (w_wr_en[j]) r_mem[r_wr_ptr + PW'(j)] <= w_wr_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_acc);
            r_rd_ptr <= r_rd_ptr + PW'(i_pop_cnt);
            r_count  <= r_count - CW'(i_pop_cnt) + CW'(w_acc);
        end
    end

    assign o_count    = r_count;
    assign o_push_cnt = w_acc;
    assign o_ovf      = (w_req != w_acc);
    assign o_head     = r_mem[r_rd_ptr];
    assign o_head1    = r_mem[r_rd_ptr + PW'(1)];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: FIFO head, head+1, a0, a1, m compete for two registered ports.
// Define WB_PERF_CNT_EN to add saturating defer/stall performance counters.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned PEND_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a0_valid,
    input  logic [31:0]  a0_res,
    input  logic [5:0]   a0_rd,
    input  logic [5:0]   a0_rob,
    input  logic [11:0]  a0_pc,
    input  logic         a1_valid,
    input  logic [31:0]  a1_res,
    input  logic [5:0]   a1_rd,
    input  logic [5:0]   a1_rob,
    input  logic [11:0]  a1_pc,
    input  logic         m_valid,
    input  logic [31:0]  m_res,
    input  logic [5:0]   m_rd,
    input  logic [5:0]   m_rob,
    input  logic [11:0]  m_pc,
    output logic [1:0]   wb_valid,
    output logic [1:0]   wb_we,
    output logic [11:0]  wb_rd,
    output logic [63:0]  wb_res,
    output logic [11:0]  wb_rob,
    output logic [23:0]  wb_pc,
    output logic         stall_o,
    output logic         ovf_err
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_defer,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    localparam int unsigned CW = $clog2(PEND_DEPTH) + 1;

    logic [CW-1:0] w_count;
    logic [1:0]    w_push_cnt;
    logic          w_fifo_ovf;
    wb_entry_t     w_head;
    wb_entry_t     w_head1;

    wb_entry_t     w_cand [5];
    logic [4:0]    w_cand_v;
    wb_entry_t     w_push_d [3];
    logic [2:0]    w_push_v;
    logic [1:0]    w_pop;
    wb_entry_t     w_win [NUM_WB_PORTS];
    logic [1:0]    w_win_v;
    logic [1:0]    w_n;

    wb_entry_t     r_ent [NUM_WB_PORTS];
    logic [1:0]    r_wb_valid;
    logic [1:0]    r_wb_we;
    logic          r_ovf_err;

    always_comb begin
        w_cand[0]   = w_head;
        w_cand[1]   = w_head1;
        w_cand[2]   = '{pc: a0_pc, rob: a0_rob, rd: a0_rd, res: a0_res};
        w_cand[3]   = '{pc: a1_pc, rob: a1_rob, rd: a1_rd, res: a1_res};
        w_cand[4]   = '{pc: m_pc, rob: m_rob, rd: m_rd, res: m_res};
        w_cand_v    = {m_valid, a1_valid, a0_valid, (w_count > CW'(1)), (w_count != '0)};
        w_push_d[0] = w_cand[2];
        w_push_d[1] = w_cand[3];
        w_push_d[2] = w_cand[4];
        w_pop       = w_cand_v[1] ? 2'd2 : (w_cand_v[0] ? 2'd1 : 2'd0);
        w_win       = '{default: '0};
        w_win_v     = 2'b00;
        w_push_v    = 3'b000;
        w_n         = 2'd0;
        // FIFO candidates sit first, so they always win before any new input.
        for (int i = 0; i < 5; i++) begin
            if (w_cand_v[i]) begin
                if (w_n < 2'd2) begin
                    w_win_v[w_n[0]] = 1'b1;
                    w_win[w_n[0]]   = w_cand[i];
                    w_n             = w_n + 2'd1;
                end else if (i >= 2) begin
                    w_push_v[i-2] = 1'b1;
                end
            end
        end
    end

    wb_pend_fifo #(
        .PEND_DEPTH (PEND_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (w_push_v),
        .i_push_data  (w_push_d),
        .i_pop_cnt    (w_pop),
        .o_count      (w_count),
        .o_push_cnt   (w_push_cnt),
        .o_ovf        (w_fifo_ovf),
        .o_head       (w_head),
        .o_head1      (w_head1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 2'b00;
            r_wb_we    <= 2'b00;
            r_ent      <= '{default: '0};
            r_ovf_err  <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_WB_PORTS; p++) begin
                r_wb_valid[p] <= w_win_v[p];
                r_wb_we[p]    <= w_win_v[p] && (w_win[p].rd != '0);
                if (w_win_v[p]) r_ent[p] <= w_win[p];
            end
            if (w_fifo_ovf) r_ovf_err <= 1'b1;
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_we    = r_wb_we;
    assign wb_rd    = {r_ent[1].rd, r_ent[0].rd};
    assign wb_res   = {r_ent[1].res, r_ent[0].res};
    assign wb_rob   = {r_ent[1].rob, r_ent[0].rob};
    assign wb_pc    = {r_ent[1].pc, r_ent[0].pc};
    // Threshold leaves room for a worst-case cycle of three pushes.
    assign stall_o  = (w_count >= CW'(PEND_DEPTH - 3));
    assign ovf_err  = r_ovf_err;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_defer;
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W:0]   w_defer_sum;

    assign w_defer_sum = {1'b0, r_perf_defer} + (CNT_W + 1)'(w_push_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_defer <= '0;
            r_perf_stall <= '0;
        end else begin
            r_perf_defer <= w_defer_sum[CNT_W] ? '1 : w_defer_sum[CNT_W-1:0];
            if (stall_o && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_defer = r_perf_defer;
    assign perf_stall = r_perf_stall;
`else
    logic w_unused_push;
    assign w_unused_push = ^w_push_cnt;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default PEND_DEPTH=8).
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a0_valid, a1_valid, m_valid;
    logic [31:0] a0_res, a1_res, m_res;
    logic [5:0]  a0_rd, a1_rd, m_rd;
    logic [5:0]  a0_rob, a1_rob, m_rob;
    logic [11:0] a0_pc, a1_pc, m_pc;
    logic [1:0]  wb_valid, wb_we;
    logic [11:0] wb_rd, wb_rob;
    logic [63:0] wb_res;
    logic [23:0] wb_pc;
    logic        stall_o, ovf_err;
`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_defer, perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt_tab [9];

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a0_valid (a0_valid),
        .a0_res   (a0_res),
        .a0_rd    (a0_rd),
        .a0_rob   (a0_rob),
        .a0_pc    (a0_pc),
        .a1_valid (a1_valid),
        .a1_res   (a1_res),
        .a1_rd    (a1_rd),
        .a1_rob   (a1_rob),
        .a1_pc    (a1_pc),
        .m_valid  (m_valid),
        .m_res    (m_res),
        .m_rd     (m_rd),
        .m_rob    (m_rob),
        .m_pc     (m_pc),
        .wb_valid (wb_valid),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_res   (wb_res),
        .wb_rob   (wb_rob),
        .wb_pc    (wb_pc),
        .stall_o  (stall_o),
        .ovf_err  (ovf_err)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_defer (perf_defer),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each source gets rd=tag, res=0x1000+tag, pc=tag.
    task automatic drive(input logic va, input logic [5:0] ta, input logic vb,
                         input logic [5:0] tb, input logic vm, input logic [5:0] tm);
        a0_valid = va; a0_rob = ta; a0_rd = ta; a0_res = 32'h1000 + 32'(ta); a0_pc = 12'(ta);
        a1_valid = vb; a1_rob = tb; a1_rd = tb; a1_res = 32'h1000 + 32'(tb); a1_pc = 12'(tb);
        m_valid  = vm; m_rob  = tm; m_rd  = tm; m_res  = 32'h1000 + 32'(tm); m_pc  = 12'(tm);
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        cnt_tab = '{0, 1, 2, 3, 4, 5, 3, 1, 0};
        do_reset();

        chk("rst_valid", 64'(wb_valid), 64'd0);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_res", wb_res, 64'd0);
        chk("rst_rob", 64'(wb_rob), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_count", 64'(dut.u_fifo.r_count), 64'd0);

        // a0 alone goes straight to port0
        drive(1'b1, 6'd3, 1'b0, 6'd0, 1'b0, 6'd0);
        a0_rd  = 6'd5;
        a0_res = 32'h11;
        tick();
        idle();
        chk("t1_valid", 64'(wb_valid), 64'h1);
        chk("t1_we", 64'(wb_we), 64'h1);
        chk("t1_rd", 64'(wb_rd[5:0]), 64'd5);
        chk("t1_res", 64'(wb_res[31:0]), 64'h11);
        chk("t1_rob", 64'(wb_rob[5:0]), 64'd3);
        chk("t1_count", 64'(dut.u_fifo.r_count), 64'd0);

        // three valids: m deferred one cycle
        drive(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);
        tick();
        idle();
        chk("t2a_valid", 64'(wb_valid), 64'h3);
        chk("t2a_rob", 64'(wb_rob), 64'({6'd2, 6'd1}));
        chk("t2a_res1", 64'(wb_res[63:32]), 64'h1002);
        chk("t2a_count", 64'(dut.u_fifo.r_count), 64'd1);
        tick();
        chk("t2b_valid", 64'(wb_valid), 64'h1);
        chk("t2b_rob", 64'(wb_rob[5:0]), 64'd3);
        chk("t2b_pc", 64'(wb_pc[11:0]), 64'd3);
        chk("t2b_count", 64'(dut.u_fifo.r_count), 64'd0);

        // rd=0 completes but does not write the PRF
        drive(1'b0, 6'd0, 1'b1, 6'd7, 1'b0, 6'd0);
        a1_rd  = 6'd0;
        a1_res = 32'hFF;
        tick();
        idle();
        chk("t3_valid", 64'(wb_valid), 64'h1);
        chk("t3_we", 64'(wb_we), 64'h0);
        chk("t3_rob", 64'(wb_rob[5:0]), 64'd7);
        chk("t3_res", 64'(wb_res[31:0]), 64'hFF);

        // five triple-valid cycles then drain; tags 1..15 must complete in order
        for (int k = 1; k <= 8; k++) begin
            if (k <= 5) drive(1'b1, 6'(3*k-2), 1'b1, 6'(3*k-1), 1'b1, 6'(3*k));
            else idle();
            tick();
            chk($sformatf("t4_valid_%0d", k), 64'(wb_valid), (k == 8) ? 64'h1 : 64'h3);
            chk($sformatf("t4_rob0_%0d", k), 64'(wb_rob[5:0]), 64'(2*k-1));
            if (k < 8) chk($sformatf("t4_rob1_%0d", k), 64'(wb_rob[11:6]), 64'(2*k));
            chk($sformatf("t4_count_%0d", k), 64'(dut.u_fifo.r_count), 64'(cnt_tab[k]));
            chk($sformatf("t4_stall_%0d", k), 64'(stall_o), (cnt_tab[k] >= 5) ? 64'd1 : 64'd0);
        end
        idle();
        tick();
        chk("t4_idle_valid", 64'(wb_valid), 64'h0);

        // fill to 8, then one more triple overflows
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 6'(3*k), 1'b1, 6'(3*k+1), 1'b1, 6'(3*k+2));
            tick();
        end
        chk("t5_count8", 64'(dut.u_fifo.r_count), 64'd8);
        chk("t5_stall", 64'(stall_o), 64'd1);
        chk("t5_ovf_pre", 64'(ovf_err), 64'd0);
        drive(1'b1, 6'd60, 1'b1, 6'd61, 1'b1, 6'd62);
        tick();
        chk("t5_ovf_set", 64'(ovf_err), 64'd1);
        chk("t5_count_cap", 64'(dut.u_fifo.r_count), 64'd8);
        idle();
        tick();
        tick();
        tick();
        chk("t5_ovf_sticky", 64'(ovf_err), 64'd1);
        chk("t5_count_drain", 64'(dut.u_fifo.r_count), 64'd2);

        // reset mid-operation with count=3
        do_reset();
        chk("t6_ovf_clr", 64'(ovf_err), 64'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'(k+1), 1'b1, 6'(k+2), 1'b1, 6'(k+3));
            tick();
        end
        chk("t6_count3", 64'(dut.u_fifo.r_count), 64'd3);
        rst = 1'b1;
        tick();
        chk("t6_count0", 64'(dut.u_fifo.r_count), 64'd0);
        chk("t6_valid", 64'(wb_valid), 64'h0);
        chk("t6_stall", 64'(stall_o), 64'd0);
`ifdef WB_PERF_CNT_EN
        chk("t6_perf_defer", 64'(perf_defer), 64'd0);
        chk("t6_perf_stall", 64'(perf_stall), 64'd0);
`endif
        rst = 1'b0;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
